// File: rtl/dt_pkg.sv
// dt_pkg: shared types and defaults for the dT estimator sequencer.
package dt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_WARM = 2'd2,
      ST_RUN  = 2'd3
   } dt_state_e;

   localparam logic [7:0] ALPHA_RST = 8'd32;
   localparam logic [7:0] KDT_RST   = 8'd0;
   localparam logic [7:0] DMAX_RST  = 8'd127;

   localparam int WARMUP_N_DEF = 8;
   localparam int GAP_MAX_DEF  = 1024;

endpackage

// File: rtl/dt_gap_wdog.sv
// dt_gap_wdog: counts consecutive enabled cycles without a clear and pulses
// hit_o on the cycle the count reaches GAP_MAX.
module dt_gap_wdog #(
   parameter int GAP_MAX = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic hit_o
);

   localparam logic [15:0] TERM = 16'(GAP_MAX - 1);

   logic [15:0] cnt_q, cnt_d;

   assign hit_o = en_i && !clr_i && (cnt_q == TERM);

   // Count idle cycles; restart on clear, on disable and after a hit.
   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (!en_i || clr_i || hit_o) cnt_d = '0;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dt_sequencer.sv
// dt_sequencer: sequences an external dT estimator (init, warm-up, run),
// holds its shadow configuration and forwards trusted results.
// Optional sample-gap watchdog: define DT_SEQUENCER_GAP_WDOG_EN.
module dt_sequencer
   import dt_pkg::*;
#(
   parameter int WARMUP_N = WARMUP_N_DEF,
   parameter int GAP_MAX  = GAP_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dt_mode,
   input  logic [7:0] t_in,
   input  logic       t_valid,
   input  logic [7:0] cfg_alpha,
   input  logic [7:0] cfg_k_dt,
   input  logic [7:0] cfg_d_max,
   input  logic       cfg_wr,
   output logic [7:0] est_T,
   output logic       est_ce,
   output logic       est_init,
   output logic [7:0] est_alpha,
   output logic [7:0] est_k_dt,
   output logic [7:0] est_d_max,
   input  logic [7:0] est_dT,
   input  logic       est_valid,
   output logic [7:0] dT_out,
   output logic       dt_upd,
   output logic       dt_ok,
   output logic [1:0] state_o,
   output logic       gap_err
);

   localparam logic [7:0] WARM_N = 8'(WARMUP_N);

   dt_state_e  state_q, state_d;
   logic [7:0] warm_q, warm_d;
   logic [7:0] t_q, t_d;
   logic       ce_q, ce_d;
   logic       init_q, init_d;
   logic       pend_q, pend_d;
   logic [7:0] stg_a_q, stg_a_d, stg_k_q, stg_k_d, stg_m_q, stg_m_d;
   logic [7:0] shd_a_q, shd_a_d, shd_k_q, shd_k_d, shd_m_q, shd_m_d;
   logic [7:0] dt_q, dt_d;
   logic       upd_q, upd_d;
   logic       active, active_nx, done, gap_hit;

   assign active    = (state_q == ST_WARM) || (state_q == ST_RUN);
   assign active_nx = (state_d == ST_WARM) || (state_d == ST_RUN);
   // A sample step completes when its result arrives the cycle after est_ce;
   // pend_q is dropped on any exit from WARM/RUN, which discards stale steps.
   assign done      = pend_q && est_valid && active;

`ifdef DT_SEQUENCER_GAP_WDOG_EN
   logic gap_err_q;

   dt_gap_wdog #(.GAP_MAX(GAP_MAX)) u_wdog (
      .clk   (clk),
      .rst   (rst),
      .en_i  (active),
      .clr_i (t_valid),
      .hit_o (gap_hit)
   );

   // Sticky watchdog flag, cleared by a config write.
   always_ff @(posedge clk) begin
      if (rst)          gap_err_q <= 1'b0;
      else if (gap_hit) gap_err_q <= 1'b1;
      else if (cfg_wr)  gap_err_q <= 1'b0;
   end

   assign gap_err = gap_err_q;
`else
   assign gap_hit = 1'b0;
   assign gap_err = 1'b0;
`endif

   // Next-state logic; dropping dt_mode overrides everything.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (dt_mode) state_d = ST_INIT;
         ST_INIT: state_d = ST_WARM;
         ST_WARM: begin
            if (cfg_wr || gap_hit)  state_d = ST_INIT;
            else if (warm_q >= WARM_N) state_d = ST_RUN;
         end
         ST_RUN:  if (cfg_wr || gap_hit) state_d = ST_INIT;
         default: state_d = ST_IDLE;
      endcase
      if (!dt_mode) state_d = ST_IDLE;
   end

   // Estimator drive, config staging/shadowing, warm count and result path.
   always_comb begin
      init_d  = (state_d == ST_INIT);
      // A sample yields a step only if we stay in WARM/RUN; INIT wins over it.
      ce_d    = init_d || (active && t_valid && !cfg_wr && active_nx);
      pend_d  = ce_q && !init_q && active_nx;
      t_d     = (active && t_valid) ? t_in : t_q;

      stg_a_d = cfg_wr ? cfg_alpha : stg_a_q;
      stg_k_d = cfg_wr ? cfg_k_dt  : stg_k_q;
      stg_m_d = cfg_wr ? cfg_d_max : stg_m_q;
      // Shadow loads on INIT entry, taking a coincident write directly.
      shd_a_d = init_d ? stg_a_d : shd_a_q;
      shd_k_d = init_d ? stg_k_d : shd_k_q;
      shd_m_d = init_d ? stg_m_d : shd_m_q;

      warm_d  = warm_q;
      if (init_d) warm_d = '0;
      else if ((state_q == ST_WARM) && done && (warm_q < WARM_N)) warm_d = warm_q + 8'd1;

      dt_d    = dt_q;
      if (state_d != ST_RUN) dt_d = '0;
      else if (done)         dt_d = est_dT;
      upd_d   = done && (state_d == ST_RUN);
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         warm_q  <= '0;
         t_q     <= '0;
         ce_q    <= 1'b0;
         init_q  <= 1'b0;
         pend_q  <= 1'b0;
         stg_a_q <= ALPHA_RST;
         stg_k_q <= KDT_RST;
         stg_m_q <= DMAX_RST;
         shd_a_q <= ALPHA_RST;
         shd_k_q <= KDT_RST;
         shd_m_q <= DMAX_RST;
         dt_q    <= '0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         t_q     <= t_d;
         ce_q    <= ce_d;
         init_q  <= init_d;
         pend_q  <= pend_d;
         stg_a_q <= stg_a_d;
         stg_k_q <= stg_k_d;
         stg_m_q <= stg_m_d;
         shd_a_q <= shd_a_d;
         shd_k_q <= shd_k_d;
         shd_m_q <= shd_m_d;
         dt_q    <= dt_d;
         upd_q   <= upd_d;
      end
   end

   assign est_T     = t_q;
   assign est_ce    = ce_q;
   assign est_init  = init_q;
   assign est_alpha = shd_a_q;
   assign est_k_dt  = shd_k_q;
   assign est_d_max = shd_m_q;
   assign dT_out    = dt_q;
   assign dt_upd    = upd_q;
   assign dt_ok     = (state_q == ST_RUN);
   assign state_o   = state_q;

endmodule

// File: tb/tb_dt_sequencer.sv
// tb_dt_sequencer: directed stimulus, a sample-level reference model checked
// every cycle, and hand-computed literal checks at key points.
module tb_dt_sequencer;

   localparam int WN = 8;
   localparam int GM = 16;
`ifdef DT_SEQUENCER_GAP_WDOG_EN
   localparam bit WDOG = 1'b1;
`else
   localparam bit WDOG = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, dt_mode, t_valid, cfg_wr;
   logic [7:0] t_in, cfg_alpha, cfg_k_dt, cfg_d_max;
   logic [7:0] est_dT = '0;
   logic       est_valid = 1'b0;
   logic [7:0] est_T, est_alpha, est_k_dt, est_d_max, dT_out;
   logic       est_ce, est_init, dt_upd, dt_ok, gap_err;
   logic [1:0] state_o;

   dt_sequencer #(.WARMUP_N(WN), .GAP_MAX(GM)) dut (
      .clk(clk), .rst(rst), .dt_mode(dt_mode), .t_in(t_in), .t_valid(t_valid),
      .cfg_alpha(cfg_alpha), .cfg_k_dt(cfg_k_dt), .cfg_d_max(cfg_d_max), .cfg_wr(cfg_wr),
      .est_T(est_T), .est_ce(est_ce), .est_init(est_init),
      .est_alpha(est_alpha), .est_k_dt(est_k_dt), .est_d_max(est_d_max),
      .est_dT(est_dT), .est_valid(est_valid),
      .dT_out(dT_out), .dt_upd(dt_upd), .dt_ok(dt_ok),
      .state_o(state_o), .gap_err(gap_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Estimator stand-in: answers every est_ce one cycle later with T-10.
   always @(posedge clk) begin
      logic       v;
      logic [7:0] t;
      v = est_ce;
      t = est_T;
      #2;
      est_valid = v;
      est_dT    = t - 8'd10;
   end

   // Reference model: phase, steps completed this epoch, pending sample steps.
   int         ph, nsteps, gapc;
   bit         issue, awaiting, mupd, mgerr;
   logic [7:0] mT, mdT, shA, shK, shD, stA, stK, stD;

   always @(posedge clk) begin
      int nph;
      bit act, nact, trip, done;
      if (rst) begin
         ph = 0; nsteps = 0; gapc = 0; issue = 0; awaiting = 0; mupd = 0; mgerr = 0;
         mT = 0; mdT = 0;
         shA = 32; shK = 0; shD = 127; stA = 32; stK = 0; stD = 127;
      end else begin
         act  = (ph >= 2);
         trip = WDOG && act && !t_valid && (gapc == GM - 1);
         if (!dt_mode)                 nph = 0;
         else if (ph == 0)             nph = 1;
         else if (ph == 1)             nph = 2;
         else if (cfg_wr || trip)      nph = 1;
         else if (ph == 2 && nsteps >= WN) nph = 3;
         else                          nph = ph;
         nact = (nph >= 2);
         done = awaiting && est_valid && act;
         awaiting = issue && nact;
         issue    = act && t_valid && !cfg_wr && nact;
         if (act && t_valid) mT = t_in;
         if (nph == 1) begin
            shA = cfg_wr ? cfg_alpha : stA;
            shK = cfg_wr ? cfg_k_dt  : stK;
            shD = cfg_wr ? cfg_d_max : stD;
         end
         if (cfg_wr) begin stA = cfg_alpha; stK = cfg_k_dt; stD = cfg_d_max; end
         if (nph == 1) nsteps = 0;
         else if (ph == 2 && done && nsteps < WN) nsteps++;
         if (nph != 3) mdT = 0;
         else if (done) mdT = est_dT;
         mupd = done && (nph == 3);
         gapc = (act && !t_valid && !trip) ? gapc + 1 : 0;
         if (trip) mgerr = 1;
         else if (cfg_wr) mgerr = 0;
         ph = nph;
      end
      #1;
      chk("m_state",  state_o,   ph);
      chk("m_init",   est_init,  ph == 1);
      chk("m_ce",     est_ce,    issue || ph == 1);
      chk("m_T",      est_T,     mT);
      chk("m_alpha",  est_alpha, shA);
      chk("m_kdt",    est_k_dt,  shK);
      chk("m_dmax",   est_d_max, shD);
      chk("m_dT",     dT_out,    mdT);
      chk("m_upd",    dt_upd,    mupd);
      chk("m_ok",     dt_ok,     ph == 3);
      chk("m_gaperr", gap_err,   mgerr);
   end

   // Feed n back-to-back samples base, base+step, ...; then stop sampling.
   task automatic samples(input int base, input int step, input int n);
      for (int i = 0; i < n; i++) begin
         t_valid = 1'b1;
         t_in    = 8'(base + step * i);
         @(negedge clk);
      end
      t_valid = 1'b0;
   endtask

   initial begin
      rst = 1; dt_mode = 0; t_valid = 0; t_in = 0; cfg_wr = 0;
      cfg_alpha = 0; cfg_k_dt = 0; cfg_d_max = 0;
      repeat (3) @(negedge clk);
      chk("rst_state", state_o, 0);
      chk("rst_alpha", est_alpha, 32);
      chk("rst_dmax",  est_d_max, 127);
      chk("rst_dT",    dT_out, 0);

      // Startup
      rst = 0; dt_mode = 1;
      @(negedge clk);
      chk("su_init_state", state_o, 1);
      chk("su_init_pulse", est_init, 1);
      chk("su_init_ce",    est_ce, 1);
      chk("su_init_T",     est_T, 0);
      @(negedge clk);
      chk("su_warm", state_o, 2);
      for (int i = 0; i < 14; i++) begin
         if (i == 10) begin
            chk("su_ok_lo", dt_ok, 0);
            chk("su_dT_lo", dT_out, 0);
         end
         if (i == 11) begin
            chk("su_ok_hi", dt_ok, 1);
            chk("su_dT_first", dT_out, 26);
            chk("su_upd_first", dt_upd, 1);
         end
         t_valid = 1; t_in = 8'(20 + 2 * i);
         @(negedge clk);
      end
      t_valid = 0;
      repeat (4) @(negedge clk);

      // Latency from one sample
      t_valid = 1; t_in = 40;
      @(negedge clk);
      t_valid = 0;
      chk("lat_ce", est_ce, 1);
      chk("lat_T",  est_T, 40);
      @(negedge clk);
      chk("lat_ce_off", est_ce, 0);
      @(negedge clk);
      chk("lat_dT",  dT_out, 30);
      chk("lat_upd", dt_upd, 1);
      @(negedge clk);
      chk("lat_upd_off", dt_upd, 0);

      // Config write during RUN with a coincident sample and a step in flight
      t_valid = 1; t_in = 48;
      @(negedge clk);
      t_valid = 1; t_in = 50; cfg_wr = 1; cfg_alpha = 128; cfg_k_dt = 3; cfg_d_max = 100;
      @(negedge clk);
      t_valid = 0; cfg_wr = 0;
      chk("cw_state", state_o, 1);
      chk("cw_T",     est_T, 50);
      chk("cw_alpha", est_alpha, 128);
      chk("cw_kdt",   est_k_dt, 3);
      chk("cw_dmax",  est_d_max, 100);
      chk("cw_ok",    dt_ok, 0);
      @(negedge clk);
      chk("cw_warm",  state_o, 2);
      chk("cw_no_ce", est_ce, 0);
      chk("cw_no_upd", dt_upd, 0);
      samples(60, 1, 14);
      chk("cw_rerun", state_o, 3);

      // dt_mode drop together with a sample
      t_valid = 1; t_in = 70; dt_mode = 0;
      @(negedge clk);
      t_valid = 0;
      chk("md_state", state_o, 0);
      chk("md_ce",    est_ce, 0);
      chk("md_dT",    dT_out, 0);
      chk("md_ok",    dt_ok, 0);
      @(negedge clk);
      chk("md_upd",   dt_upd, 0);

      // Reset one cycle after a sample
      dt_mode = 1;
      @(negedge clk);
      chk("rs_init_alpha", est_alpha, 128);
      @(negedge clk);
      t_valid = 1; t_in = 80;
      @(negedge clk);
      t_valid = 0; rst = 1;
      chk("rs_ce_pend", est_ce, 1);
      @(negedge clk);
      chk("rs_state", state_o, 0);
      chk("rs_ce",    est_ce, 0);
      chk("rs_T",     est_T, 0);
      chk("rs_alpha", est_alpha, 32);
      chk("rs_kdt",   est_k_dt, 0);
      chk("rs_dmax",  est_d_max, 127);
      chk("rs_dT",    dT_out, 0);
      rst = 0;
      @(negedge clk);
      chk("rs_init",   state_o, 1);
      chk("rs_init_T", est_T, 0);
      @(negedge clk);

      // Sample gap of GAP_MAX cycles in RUN
      samples(10, 3, 14);
      chk("gap_run", state_o, 3);
      repeat (15) @(negedge clk);
      chk("gap_pre", state_o, 3);
      @(negedge clk);
      chk("gap_state",  state_o, WDOG ? 1 : 3);
      chk("gap_flag",   gap_err, WDOG);
      @(negedge clk);
      samples(30, 1, 3);
      chk("gap_sticky", gap_err, WDOG);
      cfg_wr = 1; cfg_alpha = 40;
      @(negedge clk);
      cfg_wr = 0;
      chk("gap_clr",    gap_err, 0);
      chk("gap_cw_init", state_o, 1);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
